// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Shared constants and FSM state encoding for the DDS SPI
//               register block (frame size, address map, receiver states).
// Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

  // SPI write frame length in bits: [23:20] address, [19:16] reserved,
  // [15:0] data.
  localparam int FRAME_BITS = 24;

  // Register address map.
  localparam logic [3:0] ADDR_FREQ0_LO = 4'd0;
  localparam logic [3:0] ADDR_FREQ0_HI = 4'd1;
  localparam logic [3:0] ADDR_FREQ1_LO = 4'd2;
  localparam logic [3:0] ADDR_FREQ1_HI = 4'd3;
  localparam logic [3:0] ADDR_PHASE0   = 4'd4;
  localparam logic [3:0] ADDR_PHASE1   = 4'd5;

  // Frame receiver state encoding.
  typedef logic [1:0] spi_state_t;
  localparam spi_state_t ST_IDLE  = 2'd0;
  localparam spi_state_t ST_SHIFT = 2'd1;
  localparam spi_state_t ST_HOLD  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dds_spi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : dds_spi_frame_rx
// Description : SPI mode-0 write-frame receiver. Detects SCLK rises, shifts
//               MOSI MSB-first into a 24-bit register, flags complete frames
//               and rejects short or overrun frames.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_spi_frame_rx
  import dds_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_clock,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  frame_done,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_err
);

  localparam logic [4:0] LAST_BIT  = 5'(FRAME_BITS - 1);
  localparam logic [4:0] FULL_CNT  = 5'(FRAME_BITS);

  logic                  sclk_q;
  logic                  sclk_rise;
  spi_state_t            state;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  overrun;

  assign sclk_rise  = spi_clock & ~sclk_q;
  // shreg only moves in SHIFT, so it is stable while the parent commits it.
  assign frame_data = shreg;

  // Delay SCLK one cycle for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
    end else begin
      sclk_q <= spi_clock;
    end
  end

  // Frame FSM: chip-select framing, bit shifting, completion and error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (spi_cs_n) begin
        // Deselect wins over any SCLK rise seen in the same cycle.
        state   <= ST_IDLE;
        overrun <= 1'b0;
        if (state == ST_SHIFT && bit_cnt < FULL_CNT) begin
          frame_err <= 1'b1;
        end
        if (state == ST_HOLD && overrun) begin
          frame_err <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            overrun <= 1'b0;
          end
          ST_SHIFT: begin
            if (sclk_rise) begin
              shreg   <= {shreg[FRAME_BITS-2:0], spi_mosi};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == LAST_BIT) begin
                state      <= ST_HOLD;
                frame_done <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (sclk_rise) begin
              overrun <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dds_spi_regs.sv
`default_nettype none
// ============================================================================
// Module      : dds_spi_regs
// Description : DDS tuning register file written over SPI. Holds two
//               frequency words (committed atomically via LO staging) and two
//               phase offsets, and drives the selected pair to the DDS core.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_spi_regs
  import dds_pkg::*;
#(
  parameter int FREQ_WIDTH  = 32,
  parameter int PHASE_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   spi_clock,
  input  logic                   spi_cs_n,
  input  logic                   spi_mosi,
  input  logic                   fselect,
  input  logic                   pselect,
  output logic [FREQ_WIDTH-1:0]  freq_word,
  output logic [PHASE_WIDTH-1:0] phase_offset,
  output logic                   wr_strobe,
  output logic                   frame_err
);

  logic                   frame_done;
  logic [FRAME_BITS-1:0]  frame_data;
  logic                   rx_frame_err;
  logic [3:0]             addr;
  logic [15:0]            data;
  logic                   addr_valid;
  logic                   unused_reserved;

  logic [FREQ_WIDTH-1:0]  freq0;
  logic [FREQ_WIDTH-1:0]  freq1;
  logic [15:0]            lo_stage0;
  logic [15:0]            lo_stage1;
  logic [PHASE_WIDTH-1:0] phase0;
  logic [PHASE_WIDTH-1:0] phase1;

  dds_spi_frame_rx u_frame_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clock  (spi_clock),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .frame_done (frame_done),
    .frame_data (frame_data),
    .frame_err  (rx_frame_err)
  );

  assign addr            = frame_data[23:20];
  assign data            = frame_data[15:0];
  assign addr_valid      = (addr <= ADDR_PHASE1);
  // Reserved frame bits carry no meaning.
  assign unused_reserved = ^frame_data[19:16];

  // Commit a received frame into the register file; flag rejected frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      freq0     <= '0;
      freq1     <= '0;
      lo_stage0 <= '0;
      lo_stage1 <= '0;
      phase0    <= '0;
      phase1    <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= frame_done & addr_valid;
      frame_err <= rx_frame_err | (frame_done & ~addr_valid);
      if (frame_done) begin
        case (addr)
          ADDR_FREQ0_LO: lo_stage0 <= data;
          // Whole word updates in one cycle so the accumulator never sees a
          // half-written tuning word.
          ADDR_FREQ0_HI: freq0     <= {data[FREQ_WIDTH-17:0], lo_stage0};
          ADDR_FREQ1_LO: lo_stage1 <= data;
          ADDR_FREQ1_HI: freq1     <= {data[FREQ_WIDTH-17:0], lo_stage1};
          ADDR_PHASE0:   phase0    <= data[PHASE_WIDTH-1:0];
          ADDR_PHASE1:   phase1    <= data[PHASE_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  // Register the selected frequency and phase toward the DDS core.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      freq_word    <= '0;
      phase_offset <= '0;
    end else begin
      freq_word    <= fselect ? freq1 : freq0;
      phase_offset <= pselect ? phase1 : phase0;
    end
  end

endmodule
`default_nettype wire
